sketch_pen: RTL and testbench



---
 rtl/sketch_pen.sv | 103 ++++++++++
 tb/tb_sketch_pen.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sketch_pen.sv
// sketch_pen: synchronizes buttons/switches, moves a saturating cursor and paints or clears
// pixels of a working frame, strobing draw when a new frame is ready downstream.
module sketch_pen #(
   parameter int GRID_W      = 8,
   parameter int GRID_H      = 8,
   parameter int SCREEN_SIZE = GRID_W * GRID_H
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       move_up,
   input  logic                       move_down,
   input  logic                       move_left,
   input  logic                       move_right,
   input  logic                       pen_down,
   input  logic                       clear,
   input  logic [7:0]                 color,
   output logic                       draw,
   output logic [SCREEN_SIZE*8-1:0]   draw_image,
   output logic [$clog2(GRID_W)-1:0]  cursor_x,
   output logic [$clog2(GRID_H)-1:0]  cursor_y,
   output logic                       busy
);
   localparam int XW = $clog2(GRID_W);
   localparam int YW = $clog2(GRID_H);
   localparam int CW = $clog2(SCREEN_SIZE);

   typedef enum logic [1:0] {IDLE, PAINT, CLEAR} state_t;

   state_t          state;
   logic [5:0]      s1, s2, prev;
   logic [5:0]      raw, edges;
   logic [CW-1:0]   cnt, pix;
   logic [XW-1:0]   nx;
   logic [YW-1:0]   ny;
   logic            e_up, e_dn, e_lf, e_rt, e_pen, e_clr, any_move;

   assign raw = {clear, pen_down, move_right, move_left, move_down, move_up};
   assign edges = s2 & ~prev;
   assign {e_clr, e_pen, e_rt, e_lf, e_dn, e_up} = edges;
   assign any_move = e_up | e_dn | e_lf | e_rt;

   // opposite edges cancel; each axis saturates at the grid border
   assign nx = (e_rt & ~e_lf & (cursor_x != XW'(GRID_W - 1))) ? cursor_x + XW'(1) :
               (e_lf & ~e_rt & (cursor_x != '0))              ? cursor_x - XW'(1) : cursor_x;
   assign ny = (e_dn & ~e_up & (cursor_y != YW'(GRID_H - 1))) ? cursor_y + YW'(1) :
               (e_up & ~e_dn & (cursor_y != '0))              ? cursor_y - YW'(1) : cursor_y;
   assign pix = CW'(cursor_y) * CW'(GRID_W) + CW'(cursor_x);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1         <= '0;
         s2         <= '0;
         prev       <= '0;
         state      <= IDLE;
         busy       <= 1'b0;
         draw       <= 1'b0;
         draw_image <= '0;
         cursor_x   <= '0;
         cursor_y   <= '0;
         cnt        <= '0;
      end else begin
         s1   <= raw;
         s2   <= s1;
         prev <= s2;
         draw <= 1'b0;
         case (state)
            IDLE: begin
               if (e_clr) begin
                  state <= CLEAR;
                  busy  <= 1'b1;
                  cnt   <= '0;
               end else if (any_move) begin
                  cursor_x <= nx;
                  cursor_y <= ny;
                  if (s2[4]) begin
                     state <= PAINT;
                     busy  <= 1'b1;
                  end
               end else if (e_pen) begin
                  state <= PAINT;
                  busy  <= 1'b1;
               end
            end
            PAINT: begin
               draw_image[{pix, 3'b000} +: 8] <= color;
               draw  <= 1'b1;
               state <= IDLE;
               busy  <= 1'b0;
            end
            CLEAR: begin
               draw_image[{cnt, 3'b000} +: 8] <= '0;
               cnt <= cnt + CW'(1);
               if (cnt == CW'(SCREEN_SIZE - 1)) begin
                  draw  <= 1'b1;
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sketch_pen.sv
// tb_sketch_pen: directed and randomized button sequences checked against a per-press model.
module tb_sketch_pen;
   localparam int W = 8;
   localparam int H = 8;
   localparam int N = W * H;

   logic           clk = 1'b0, rst_n = 1'b0;
   logic           move_up = 1'b0, move_down = 1'b0, move_left = 1'b0, move_right = 1'b0;
   logic           pen_down = 1'b0, clear = 1'b0;
   logic [7:0]     color = '0;
   logic           draw, busy;
   logic [N*8-1:0] draw_image;
   logic [2:0]     cursor_x, cursor_y;

   always #5 clk = ~clk;

   sketch_pen dut (
      .clk(clk), .rst_n(rst_n), .move_up(move_up), .move_down(move_down),
      .move_left(move_left), .move_right(move_right), .pen_down(pen_down),
      .clear(clear), .color(color), .draw(draw), .draw_image(draw_image),
      .cursor_x(cursor_x), .cursor_y(cursor_y), .busy(busy)
   );

   int   n_tests = 0, n_fail = 0, n_draw = 0, n_dbl = 0, exp_draw = 0;
   logic last_draw = 1'b0;
   int   mx = 0, my = 0;
   bit   mpen = 0;
   logic [7:0] mf [N];

   always @(negedge clk) begin
      if (draw === 1'b1) n_draw++;
      if (draw === 1'b1 && last_draw === 1'b1) n_dbl++;
      last_draw = draw;
   end

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [N*8-1:0] frame();
      logic [N*8-1:0] f;
      for (int k = 0; k < N; k++) f[8*k +: 8] = mf[k];
      return f;
   endfunction

   function automatic int clamp(input int v, input int hi);
      return v < 0 ? 0 : (v > hi ? hi : v);
   endfunction

   task automatic model_reset();
      mx = 0;
      my = 0;
      mpen = 0;
      for (int k = 0; k < N; k++) mf[k] = '0;
   endtask

   task automatic check_state(input string tag);
      check({tag, "_x"}, cursor_x, mx);
      check({tag, "_y"}, cursor_y, my);
      check({tag, "_img"}, draw_image, frame());
      check({tag, "_draws"}, n_draw, exp_draw);
      check({tag, "_busy"}, busy, 0);
   endtask

   task automatic settle();
      for (int i = 0; i < 200 && busy === 1'b1; i++) @(negedge clk);
      repeat (3) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      {move_up, move_down, move_left, move_right, pen_down, clear} = '0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      exp_draw = n_draw;
      repeat (2) @(negedge clk);
   endtask

   // one press: the model decides the outcome from the press itself, then the DUT is driven
   task automatic act(input bit up, input bit dn, input bit lf, input bit rt, input bit clr,
                      input bit pn, input logic [7:0] col, input bit timed);
      bit paint = 0;
      if (clr) begin
         for (int k = 0; k < N; k++) mf[k] = '0;
         exp_draw++;
      end else if (up | dn | lf | rt) begin
         mx = clamp(mx + int'(rt) - int'(lf), W - 1);
         my = clamp(my + int'(dn) - int'(up), H - 1);
         paint = pn;
      end else if (pn && !mpen) paint = 1;
      if (paint) begin
         mf[my*W + mx] = col;
         exp_draw++;
      end
      mpen = pn;
      @(negedge clk);
      {move_up, move_down, move_left, move_right, clear, pen_down} = {up, dn, lf, rt, clr, pn};
      color = col;
      repeat (3) @(posedge clk);
      #1;
      if (timed) check("pre_strobe", draw, 0);
      @(posedge clk);
      #1;
      if (timed) begin
         check("strobe", draw, 1);
         check("strobe_img", draw_image, frame());
      end
      @(negedge clk);
      {move_up, move_down, move_left, move_right, clear} = '0;
      settle();
      check_state("act");
   endtask

   initial begin
      int bc;
      model_reset();
      do_reset();
      check_state("reset");

      repeat (3) act(0, 0, 0, 1, 0, 0, 8'h00, 0);
      check("three_right_x", cursor_x, 3);

      do_reset();
      act(0, 1, 0, 0, 0, 1, 8'hE0, 1);
      check("pix8", draw_image[8*W +: 8], 8'hE0);

      do_reset();
      act(1, 0, 1, 0, 0, 0, 8'h00, 0);
      repeat (7) act(0, 1, 0, 1, 0, 0, 8'h00, 0);
      act(0, 0, 0, 1, 0, 0, 8'h00, 0);
      act(0, 0, 1, 1, 0, 0, 8'h00, 0);
      check("corner", {cursor_y, cursor_x}, 6'o77);

      repeat (5) act(0, 0, 1, 0, 0, 0, 8'h00, 0);
      repeat (2) act(1, 0, 0, 0, 0, 0, 8'h00, 0);
      act(0, 0, 0, 0, 0, 1, 8'h1C, 1);
      check("pix42", draw_image[8*42 +: 8], 8'h1C);
      repeat (2) act(0, 0, 0, 0, 0, 1, 8'h55, 0);
      act(0, 0, 0, 1, 0, 1, 8'hA1, 0);
      act(0, 1, 0, 0, 0, 1, 8'hA2, 0);

      // clear with a move pulse landing mid-clear
      @(negedge clk);
      clear = 1'b1;
      for (int k = 0; k < N; k++) mf[k] = '0;
      exp_draw++;
      for (int i = 0; i < 20 && busy !== 1'b1; i++) @(negedge clk);
      bc = 0;
      while (busy === 1'b1 && bc < 200) begin
         bc++;
         if (bc == 3) clear = 1'b0;
         if (bc == 10) move_right = 1'b1;
         if (bc == 16) move_right = 1'b0;
         @(negedge clk);
      end
      check("clear_busy_cycles", bc, N);
      check("clear_strobe", draw, 1);
      check("clear_img", draw_image, 0);
      settle();
      check_state("clear");

      for (int t = 0; t < 40; t++) begin
         bit c, u, d, l, r, p;
         c = ($urandom_range(0, 7) == 0);
         {u, d, l, r} = 4'($urandom);
         p = ($urandom_range(0, 2) == 0) ? !mpen : mpen;
         act(u, d, l, r, c, p, 8'($urandom), 0);
      end

      // reset in the middle of a clear
      act(0, 0, 0, 0, 0, 1, 8'h77, 0);
      act(0, 0, 0, 0, 0, 0, 8'h00, 0);
      @(negedge clk);
      clear = 1'b1;
      for (int i = 0; i < 20 && busy !== 1'b1; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      clear = 1'b0;
      repeat (17) @(negedge clk);
      check("midclear_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check("rst_img", draw_image, 0);
      check("rst_cursor", {cursor_y, cursor_x}, 0);
      check("rst_busy", busy, 0);
      check("rst_draw", draw, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      exp_draw = n_draw;
      repeat (80) @(negedge clk);
      check_state("after_rst");
      check("no_double_strobe", n_dbl, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
